// File: rtl/mult_hilo_unit.sv
// Iterative radix-2 shift-add multiplier for MIPS MULT/MULTU that owns the HI/LO registers.
// A start/busy/done handshake lets pipeline control stall MFHI/MFLO until the product lands.
module mult_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic               accept, last, wr_ok, neg;
  logic [WIDTH-1:0]   mag_a, mag_b, mplier;
  logic [2*WIDTH-1:0] mcand, acc, acc_sum, product;
  logic [CW-1:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = (state != BUSY) && start && !flush;
    last     = (state == BUSY) && (count == CW'(WIDTH - 1));
    wr_ok    = (state != BUSY) && !start;
    mag_a    = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b    = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    acc_sum  = mplier[0] ? acc + mcand : acc;
    product  = neg ? -acc_sum : acc_sum;
    case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: begin
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = accept ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The multiplicand shifts left and the multiplier right each step, which is
  // the same sum as adding multiplicand<<count whenever multiplier[count] is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      count  <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      acc    <= '0;
      count  <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (last && !flush) begin
      {hi, lo} <= product;
    end else if (wr_ok) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed self-checking bench for mult_hilo_unit: products, latency, handshake,
// flush, MTHI/MTLO and asynchronous reset behaviour.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed, flush, hi_we, lo_we;
  logic [31:0] op_a, op_b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Counts cycles until done, bounded; also notes whether busy ever dropped.
  task automatic wait_done(output int cyc, output logic busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {busy, done}); else passed++;
  endtask

  task automatic test_multu_max;
    int cyc; logic bok;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc, bok);
    total++; if (cyc !== 32) $display("FAIL multu_latency: got %0d expected 32", cyc); else passed++;
    total++; if (bok !== 1'b1) $display("FAIL multu_busy: got %b expected 1", bok); else passed++;
    total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
      $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo); else passed++;
    tick;
    total++; if ({busy, done} !== 2'b00) $display("FAIL done_pulse: got %b expected 00", {busy, done}); else passed++;
  endtask

  task automatic test_signed;
    int cyc; logic bok;
    issue(32'hFFFF_FFFD, 32'd5, 1'b1);
    repeat (10) tick;
    total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1)
      $display("FAIL hold_during_busy: got %h_%h expected fffffffe_00000001", hi, lo); else passed++;
    wait_done(cyc, bok);
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || done !== 1'b1)
      $display("FAIL mult_neg3x5: got %h_%h done=%b expected ffffffff_fffffff1 done=1", hi, lo, done); else passed++;
    tick;
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(cyc, bok);
    total++; if (hi !== 32'h4000_0000 || lo !== 32'h0)
      $display("FAIL mult_minmin: got %h_%h expected 40000000_00000000", hi, lo); else passed++;
    tick;
    issue(32'h8000_0000, 32'd1, 1'b1);
    wait_done(cyc, bok);
    total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'h8000_0000)
      $display("FAIL mult_min_x1: got %h_%h expected ffffffff_80000000", hi, lo); else passed++;
    tick;
    issue(32'h8000_0000, 32'd2, 1'b0);
    wait_done(cyc, bok);
    total++; if (hi !== 32'h1 || lo !== 32'h0)
      $display("FAIL multu_min_x2: got %h_%h expected 00000001_00000000", hi, lo); else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    int cyc; logic bok;
    issue(32'd7, 32'd0, 1'b1);
    wait_done(cyc, bok);
    total++; if (hi !== 32'h0 || lo !== 32'h0 || done !== 1'b1)
      $display("FAIL b2b_first: got %h_%h done=%b expected 0_0 done=1", hi, lo, done); else passed++;
    issue(32'h0001_0000, 32'h0001_0000, 1'b0);
    total++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept: got %b expected 10", {busy, done}); else passed++;
    wait_done(cyc, bok);
    total++; if (cyc !== 32) $display("FAIL b2b_latency: got %0d expected 32", cyc); else passed++;
    total++; if (hi !== 32'h1 || lo !== 32'h0)
      $display("FAIL b2b_second: got %h_%h expected 00000001_00000000", hi, lo); else passed++;
    tick;
  endtask

  task automatic test_start_while_busy;
    int cyc; logic bok;
    issue(32'd2, 32'd3, 1'b0);
    repeat (4) tick;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(cyc, bok);
    total++; if (cyc !== 27) $display("FAIL busy_ignore_latency: got %0d expected 27", cyc); else passed++;
    total++; if (hi !== 32'h0 || lo !== 32'd6)
      $display("FAIL busy_ignore_result: got %h_%h expected 00000000_00000006", hi, lo); else passed++;
    tick;
  endtask

  task automatic test_flush_and_mt;
    int cyc; logic bok; logic seen;
    issue(32'd4, 32'd4, 1'b0);
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++; if ({busy, done} !== 2'b00) $display("FAIL flush_state: got %b expected 00", {busy, done}); else passed++;
    seen = 1'b0;
    repeat (40) begin tick; if (done) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", seen); else passed++;
    total++; if (hi !== 32'h0 || lo !== 32'd6)
      $display("FAIL flush_hilo: got %h_%h expected 00000000_00000006", hi, lo); else passed++;
    wdata = 32'h0000_ABCD; lo_we = 1'b1;
    tick;
    lo_we = 1'b0;
    total++; if (lo !== 32'h0000_ABCD || hi !== 32'h0)
      $display("FAIL mtlo: got %h_%h expected 00000000_0000abcd", hi, lo); else passed++;
    issue(32'd1, 32'd1, 1'b0);
    wdata = 32'hDEAD_BEEF; hi_we = 1'b1;
    tick;
    hi_we = 1'b0;
    total++; if (hi !== 32'h0) $display("FAIL mthi_busy: got %h expected 00000000", hi); else passed++;
    wait_done(cyc, bok);
    total++; if (hi !== 32'h0 || lo !== 32'h1)
      $display("FAIL mult_1x1: got %h_%h expected 00000000_00000001", hi, lo); else passed++;
    tick;
    wdata = 32'h0000_0055; hi_we = 1'b1; lo_we = 1'b1;
    tick;
    hi_we = 1'b0; lo_we = 1'b0;
    total++; if (hi !== 32'h55 || lo !== 32'h55)
      $display("FAIL mt_both: got %h_%h expected 00000055_00000055", hi, lo); else passed++;
  endtask

  task automatic test_async_reset;
    logic seen;
    issue(32'd6, 32'd7, 1'b1);
    repeat (14) tick;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({hi, lo} !== 64'h0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset: got %h_%h busy=%b done=%b expected 0_0 busy=0 done=0", hi, lo, busy, done); else passed++;
    #10 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin tick; if (done || busy) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("FAIL reset_no_done: got %b expected 0", seen); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; op_a = '0; op_b = '0; wdata = '0;
    repeat (3) tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_multu_max;
    test_signed;
    test_back_to_back;
    test_start_while_busy;
    test_flush_and_mt;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
